// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// The master drives operands and start; the slave returns the result and status.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b,
    input  sum, cout, busy, done
  );

  modport slave (
    input  start, a, b,
    output sum, cout, busy, done
  );
endinterface

// File: rtl/serial_adder_fsm.sv
// Bit-serial WIDTH-bit adder: one full-adder evaluation per clock, LSB first,
// with a registered carry; parallel sum/cout are published with a one-cycle done pulse.
module serial_adder_fsm #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             carry;
  logic             carry_next;
  logic             bit_s;
  logic [CNT_W-1:0] cnt;
  logic             load;
  logic             last;
  logic             busy_s;
  logic             done_s;

  // {carry_out, sum_bit} of a single full-adder cell
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    full_add = {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

  assign {carry_next, bit_s} = full_add(a_sr[0], b_sr[0], carry);

  // The DONE cycle accepts a new start so back-to-back operations have no IDLE gap.
  assign load = bus.start && ((state == IDLE) || (state == DONE));
  assign last = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last)      state_next = DONE;
      DONE:    state_next = bus.start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state)
      RUN:     busy_s = 1'b1;
      DONE:    done_s = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
    end else if (load) begin
      a_sr   <= bus.a;
      b_sr   <= bus.b;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (state == RUN) begin
      // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
      res_sr <= {bit_s, res_sr[WIDTH-1:1]};
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      carry  <= carry_next;
      cnt    <= cnt + 1'b1;
      if (last) begin
        sum_r  <= {bit_s, res_sr[WIDTH-1:1]};
        cout_r <= carry_next;
      end
    end
  end

  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
  assign bus.busy = busy_s;
  assign bus.done = done_s;

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Scoreboard bench for serial_adder_fsm: accepted operations push a+b into a queue,
// each done pulse pops and compares; status and held outputs are checked every cycle.
module tb_serial_adder_fsm;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int total = 0;
  int bad   = 0;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder_fsm #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model of the transaction-level behaviour (0=idle, 1=run, 2=done).
  int         m_state = 0;
  int         m_cnt   = 0;
  logic [W:0] m_cur   = '0;
  logic [W:0] m_held  = '0;
  logic [W:0] sb_q[$];

  always @(posedge clk) begin
    if (rst) begin
      m_state <= 0;
      m_cnt   <= 0;
      m_held  <= '0;
      sb_q.delete();
    end else begin
      case (m_state)
        1: begin
          if (m_cnt == W - 1) begin
            m_state <= 2;
            m_held  <= m_cur;
          end else begin
            m_cnt <= m_cnt + 1;
          end
        end
        default: begin
          if (bus.start) begin
            m_cur   <= {1'b0, bus.a} + {1'b0, bus.b};
            sb_q.push_back({1'b0, bus.a} + {1'b0, bus.b});
            m_state <= 1;
            m_cnt   <= 0;
          end else begin
            m_state <= 0;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    logic [W:0] exp_res;
    check("busy", bus.busy, (m_state == 1));
    check("done", bus.done, (m_state == 2));
    check("held", {bus.cout, bus.sum}, m_held);
    if (bus.done) begin
      if (sb_q.size() == 0) begin
        check("sb_empty_on_done", sb_q.size(), 1);
      end else begin
        exp_res = sb_q.pop_front();
        check("sb_result", {bus.cout, bus.sum}, exp_res);
      end
    end
  end

  // Runs from a negedge until done is seen (returned at that negedge) or budget expires.
  // Start is dropped after the first cycle unless hold; optional mid-run start/rst injection.
  task automatic wait_done(input int budget, input bit expect_done, input bit hold,
                           input int inj_k, input logic [W-1:0] ia, input logic [W-1:0] ib,
                           input int rst_k,
                           output int cycles, output int busy_cnt, output bit seen);
    cycles   = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      cycles = k;
      if (!hold) bus.start = 1'b0;
      rst = (k == rst_k);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy) busy_cnt++;
      if (k == inj_k) begin
        bus.start = 1'b1;
        bus.a     = ia;
        bus.b     = ib;
      end
    end
    if (expect_done && !seen) check("timeout_done", bus.done, 1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [W-1:0] exp_sum, input logic exp_cout);
    int cyc;
    int bcnt;
    bit seen;
    bus.a     = va;
    bus.b     = vb;
    bus.start = 1'b1;
    wait_done(30, 1'b1, 1'b0, 0, '0, '0, 0, cyc, bcnt, seen);
    check({tag, "_sum"},  bus.sum,  exp_sum);
    check({tag, "_cout"}, bus.cout, exp_cout);
    check({tag, "_busy_cycles"}, bcnt, W);
    check({tag, "_latency"}, cyc, W + 1);
  endtask

  initial begin
    int cyc;
    int bcnt;
    bit seen;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    check("reset_sum",  bus.sum,  0);
    check("reset_cout", bus.cout, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op("add_3c_0f", 8'h3C, 8'h0F, 8'h4B, 1'b0);
    @(negedge clk);
    run_op("add_ff_01", 8'hFF, 8'h01, 8'h00, 1'b1);
    run_op("add_ff_ff", 8'hFF, 8'hFF, 8'hFE, 1'b1);
    repeat (2) @(negedge clk);

    // Start during the 3rd RUN cycle must be ignored.
    bus.a = 8'h10; bus.b = 8'h20; bus.start = 1'b1;
    wait_done(30, 1'b1, 1'b0, 3, 8'h55, 8'h55, 0, cyc, bcnt, seen);
    check("ign_sum",  bus.sum,  8'h30);
    check("ign_cout", bus.cout, 1'b0);
    check("ign_latency", cyc, W + 1);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("ign_idle_busy", bus.busy, 0);

    // Reset in the 4th RUN cycle aborts with no done pulse.
    bus.a = 8'hAA; bus.b = 8'h55; bus.start = 1'b1;
    wait_done(15, 1'b0, 1'b0, 0, '0, '0, 4, cyc, bcnt, seen);
    rst = 1'b0;
    check("abort_no_done", seen, 0);
    check("abort_sum",  bus.sum,  0);
    check("abort_cout", bus.cout, 0);
    check("abort_busy", bus.busy, 0);
    run_op("after_abort", 8'h01, 8'h02, 8'h03, 1'b0);

    // Held start: back-to-back operations, second captures operands changed during RUN.
    @(negedge clk);
    bus.a = 8'h80; bus.b = 8'h80; bus.start = 1'b1;
    wait_done(30, 1'b1, 1'b1, 3, 8'h01, 8'h01, 0, cyc, bcnt, seen);
    check("b2b1_sum",  bus.sum,  8'h00);
    check("b2b1_cout", bus.cout, 1'b1);
    wait_done(30, 1'b1, 1'b1, 0, '0, '0, 0, cyc, bcnt, seen);
    bus.start = 1'b0;
    check("b2b2_sum",  bus.sum,  8'h02);
    check("b2b2_cout", bus.cout, 1'b0);
    check("b2b_period", cyc, W + 1);
    check("b2b_busy_cycles", bcnt, W);

    // Reset then a long idle stretch: nothing may start.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.busy || bus.done) bcnt++;
    end
    check("idle_no_activity", bcnt, 0);
    check("idle_sum",  bus.sum,  0);
    check("idle_cout", bus.cout, 0);
    check("sb_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder_fsm.md
Name: serial_adder_fsm

Overview:
Bit-serial N-bit adder built around the half-adder/full-adder primitive: accepts two parallel operands on a start pulse, adds them LSB-first one bit per clock with a registered carry, and presents the parallel sum and carry-out with a done pulse. It is the sequential stage next to the combinational adders: it drives one sum/carry evaluation per cycle and registers the result. It also serves as a low-area alternative to a ripple adder.

Parameters:
WIDTH, 8, operand and sum width in bits (>= 2)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  load request; sampled only when not busy
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
sum  output  WIDTH  registered sum, valid while done is high and held until the next accepted start
cout  output  1  registered carry-out of bit WIDTH-1, same validity as sum
busy  output  1  high while addition is in progress
done  output  1  single-cycle pulse when sum/cout become valid

Behaviour:
- One clock, synchronous active-high reset: on any rising edge with rst=1, state=IDLE, sum=0, cout=0, busy=0, done=0, internal shift registers, carry and bit counter cleared. rst overrides start.
- States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. start=1 -> capture a, b into shift regs, clear carry, counter=0, go to RUN.
- RUN: busy=1. Each cycle: bit = a_sr[0] ^ b_sr[0] ^ c; c_next = (a_sr[0]&b_sr[0]) | (c&(a_sr[0]^b_sr[0])). Shift bit into the result register from the MSB side, shift a_sr, b_sr right by 1, counter++. After the WIDTH-th bit (counter==WIDTH-1), load sum from the completed result register, cout=c_next, go to DONE.
- DONE: lasts exactly one cycle. done=1, busy=0. Next state is IDLE unless start=1, which reloads and goes to RUN directly. A back-to-back start is allowed.
- Latency: start sampled at edge E0 -> busy high after E0 for WIDTH cycles -> done high for one cycle after edge E0+WIDTH.
- sum/cout change only on the RUN->DONE transition and on reset. Outside that transition they hold the last result.
- start while in RUN is ignored. Operands are not re-captured and the in-flight result is unaffected.
- a/b changes after capture have no effect.
- Reset mid-RUN aborts the operation. No done pulse. Outputs are zero on the next cycle.
- Arithmetic is modulo 2^WIDTH in sum, with the overflow bit in cout. Unsigned: {cout,sum} = a + b exactly.

Test Plan:
- WIDTH=8, a=0x3C, b=0x0F, start 1 cycle -> busy high 8 cycles, then done=1 for 1 cycle with sum=0x4B, cout=0.
- a=0xFF, b=0x01 -> sum=0x00, cout=1 (full carry ripple through all bits). a=0xFF, b=0xFF -> sum=0xFE, cout=1.
- Start a=0x10, b=0x20, then assert start with a=0x55, b=0x55 on the 3rd RUN cycle -> ignored. Result sum=0x30, cout=0, done after 8 cycles from the first start.
- Start a=0xAA, b=0x55, assert rst on the 4th RUN cycle -> next cycle sum=0, cout=0, busy=0, done=0. No done pulse follows. A new start with a=0x01, b=0x02 gives sum=0x03.
- Hold start=1 continuously with a=0x80, b=0x80, then change to a=0x01, b=0x01 during RUN -> first done gives sum=0x00, cout=1. A new operation starts in the DONE cycle, with no IDLE gap, and captures the then-current operands. Every 9 cycles done pulses: the second gives sum=0x02, cout=0.
- Apply reset, then leave start low for 20 cycles -> all outputs remain 0 and busy never rises.
